wb_shared_intercon: RTL and testbench
=====================================

Name: wb_shared_intercon

Overview:
- Parametrised shared-bus WISHBONE (classic cycle) interconnect: NUM_MASTERS masters share one bus to NUM_SLAVES slaves.
- Registered round-robin arbitration; address decode from BASE/MASK parameter vectors.
- Internal default slave returns ERR for unmapped addresses; a per-transfer watchdog terminates hung accesses with ERR.
- Sits between the register masters (BMC, SPI, PCIe bridges) and the register/RAM slaves.

Parameters:
NUM_MASTERS, 3, number of masters (1..8)
NUM_SLAVES, 6, number of slaves (1..16)
AW, 22, address width
DW, 32, data width; select width is DW/8
SLAVE_BASE, 0, NUM_SLAVES*AW flat vector; slave k base at bits [k*AW +: AW]
SLAVE_MASK, 0, NUM_SLAVES*AW flat vector; 1-bits are passed through to the slave, not decoded
TIMEOUT, 255, watchdog limit in cycles (16-bit); 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
m_cyc_i/m_stb_i/m_we_i  in  NUM_MASTERS each  master controls
m_adr_i  in  NUM_MASTERS*AW  master addresses
m_dat_i  in  NUM_MASTERS*DW  master write data
m_sel_i  in  NUM_MASTERS*DW/8  master byte selects
m_dat_o  out  DW  muxed read data, common to all masters
m_ack_o/m_err_o/m_rty_o  out  NUM_MASTERS each  terminations, granted master only
s_cyc_o/s_stb_o/s_we_o  out  NUM_SLAVES each  slave controls, selected slave only
s_adr_o  out  AW  granted address AND slave mask (shared bus)
s_dat_o  out  DW  granted write data
s_sel_o  out  DW/8  granted selects
s_dat_i  in  NUM_SLAVES*DW  slave read data
s_ack_i/s_err_i/s_rty_i  in  NUM_SLAVES each  slave terminations
gnt_o  out  NUM_MASTERS  current one-hot grant (debug)
timeout_o  out  1  one-cycle pulse on watchdog expiry
timeout_adr_o  out  AW  full address of the last timed-out transfer

Behaviour:
- Reset (async assert, sync release): gnt=0, arbiter IDLE, last-grant pointer=NUM_MASTERS-1, watchdog=0, timeout_o=0, timeout_adr_o=0. All slave/master controls are 0 because gnt=0.
- Arbiter FSM:
  - IDLE: if any m_cyc_i, register a one-hot grant to the first requester searching from last+1 upward with wrap. Go to OWNED; grant is visible the next cycle.
  - OWNED: hold the grant while that master's cyc is high. When cyc falls, clear gnt, update the pointer, return to IDLE.
  - Minimum one idle cycle between owners. Same master re-requesting competes normally and loses to other requesters.
- Bus mux: cyc/stb/we/adr/dat/sel are taken from the granted master; all are 0 when nothing is granted.
- Decode is combinational: slave k is hit when (adr & ~MASK_k) == BASE_k. On multiple hits, the lowest k wins.
  - s_cyc_o[k]/s_stb_o[k]/s_we_o[k] assert only for the winning k. s_adr_o = adr & MASK_winner, or 0 on a miss.
- Return path: m_dat_o = s_dat_i of the hit slave, otherwise 0.
  - m_ack_o/m_rty_o/m_err_o = hit slave's terminations ANDed with gnt.
  - m_err_o additionally ORs in default-slave err and watchdog err.
- Default slave: on a miss with cyc&stb, registered err is asserted the following cycle for one cycle, then the block waits for stb to fall before it can err again. If stb drops first, no err is issued.
- Watchdog:
  - Counter is cleared when the bus is idle, stb is low, or any termination occurs. It increments while cyc&stb are high to a hit slave without a termination.
  - When the count reaches TIMEOUT and no termination arrives that cycle: m_err_o pulses 1 cycle to the granted master, timeout_o pulses, timeout_adr_o latches the full address, counter clears.
  - A slave termination arriving in the expiry cycle wins; no timeout occurs.
  - After expiry, s_stb_o to that slave is forced low until the master drops stb. A late slave ack is ignored.
- Reset mid-transfer: everything returns to reset values immediately; no termination is generated.

Test Plan:
- NUM_MASTERS=3; masters 0 and 2 raise cyc in the same cycle from reset. Required: master 0 granted first, master 2 next (1 idle cycle between). Master 0 re-requesting while 2 owns gets granted after 2.
- SLAVE_BASE/MASK from the register map; read 0x04_1234 with slave 4 at base 0x040000, mask 0x33FFFF. Required: only s_stb_o[4] asserted, s_adr_o=0x001234. m_dat_o = s_dat_i slice 4 (0xDEADBEEF); ack goes to the granted master only.
- Access 0x3F0000 (unmapped). Required: no s_cyc_o asserted; m_err_o pulses exactly 1 cycle, 1 cycle after stb.
- TIMEOUT=8, slave never acks. Required: err + timeout_o on stb-high cycle 9 (counter reaches 8); timeout_adr_o = issued address; s_stb_o low afterward; a later slave ack is not propagated.
- TIMEOUT=8, slave acks exactly on the expiry cycle. Required: m_ack_o=1, m_err_o=0, timeout_o=0.
- rst_ni pulsed low mid-transfer, asynchronous to clk_i. Required: gnt_o, all s_*_o and m_*_o terminations 0 before the next edge; round robin restarts with master 0.

Source files
------------

// File: rtl/wb_shared_intercon.sv
// Shared-bus WISHBONE classic interconnect: round-robin master arbitration,
// BASE/MASK slave decode, default ERR slave and per-transfer watchdog.
module wb_shared_intercon #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned NUM_SLAVES  = 6,
    parameter int unsigned AW          = 22,
    parameter int unsigned DW          = 32,
    parameter logic [NUM_SLAVES*AW-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*AW-1:0] SLAVE_MASK = '0,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [NUM_MASTERS-1:0]      m_rty_o,
    output logic [NUM_SLAVES-1:0]       s_cyc_o,
    output logic [NUM_SLAVES-1:0]       s_stb_o,
    output logic [NUM_SLAVES-1:0]       s_we_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    input  logic [NUM_SLAVES*DW-1:0]    s_dat_i,
    input  logic [NUM_SLAVES-1:0]       s_ack_i,
    input  logic [NUM_SLAVES-1:0]       s_err_i,
    input  logic [NUM_SLAVES-1:0]       s_rty_i,
    output logic [NUM_MASTERS-1:0]      gnt_o,
    output logic                        timeout_o,
    output logic [AW-1:0]               timeout_adr_o
);

    localparam int unsigned SW  = DW / 8;
    localparam int unsigned MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned SIW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [15:0]    TO_LIMIT = 16'(TIMEOUT);
    localparam logic [MIW-1:0] LAST_RST = MIW'(NUM_MASTERS - 1);

    typedef enum logic [0:0] {ST_IDLE, ST_OWNED} arb_state_e;

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [MIW-1:0]         last_q, last_d;
    logic [MIW-1:0]         owner_q, owner_d;
    logic                   arb_found;
    int                     arb_cand;

    logic                   bus_cyc, bus_stb, bus_we;
    logic [AW-1:0]          bus_adr;
    logic [DW-1:0]          bus_dat;
    logic [SW-1:0]          bus_sel;

    logic                   hit_c;
    logic [SIW-1:0]         hit_idx;
    logic [AW-1:0]          win_mask;
    logic [DW-1:0]          hit_dat;

    logic                   slv_ack_c, slv_err_c, slv_rty_c, slv_term_c;
    logic                   miss_c, de_err_c;
    logic                   de_err_q, de_err_d, de_done_q, de_done_d;
    logic                   wd_active_c, wd_exp_c;
    logic [15:0]            wd_cnt_q, wd_cnt_d;
    logic                   wd_block_q, wd_block_d;
    logic [AW-1:0]          tadr_q, tadr_d;

    // Arbiter state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    // Arbiter next state: round-robin pick from last+1, hold while owner's cyc is high
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        arb_found = 1'b0;
        arb_cand  = 0;
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    for (int i = 1; i <= int'(NUM_MASTERS); i++) begin
                        arb_cand = (int'(last_q) + i) % int'(NUM_MASTERS);
                        if (!arb_found && m_cyc_i[MIW'(arb_cand)]) begin
                            arb_found = 1'b1;
                            owner_d   = MIW'(arb_cand);
                        end
                    end
                    gnt_d          = '0;
                    gnt_d[owner_d] = 1'b1;
                    state_d        = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (!m_cyc_i[owner_q]) begin
                    gnt_d   = '0;
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shared bus mux from the granted master; all zero when nothing is granted
    always_comb begin
        bus_cyc = 1'b0;
        bus_stb = 1'b0;
        bus_we  = 1'b0;
        bus_adr = '0;
        bus_dat = '0;
        bus_sel = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (gnt_q[i]) begin
                bus_cyc = m_cyc_i[i];
                bus_stb = m_stb_i[i];
                bus_we  = m_we_i[i];
                bus_adr = m_adr_i[i*AW +: AW];
                bus_dat = m_dat_i[i*DW +: DW];
                bus_sel = m_sel_i[i*SW +: SW];
            end
        end
    end

    // Address decode; descending scan leaves the lowest matching slave as winner
    always_comb begin
        hit_c    = 1'b0;
        hit_idx  = '0;
        win_mask = '0;
        for (int k = int'(NUM_SLAVES) - 1; k >= 0; k--) begin
            if ((bus_adr & ~SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]) begin
                hit_c    = bus_cyc;
                hit_idx  = SIW'(k);
                win_mask = SLAVE_MASK[k*AW +: AW];
            end
        end
    end

    // Read data mux from the hit slave
    always_comb begin
        hit_dat = '0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            if (hit_c && (SIW'(k) == hit_idx)) begin
                hit_dat = s_dat_i[k*DW +: DW];
            end
        end
    end

    // Slave-side controls: only the winning slave sees cyc/stb/we; stb blocked after expiry
    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        s_we_o  = '0;
        if (hit_c) begin
            s_cyc_o[hit_idx] = 1'b1;
            s_stb_o[hit_idx] = bus_stb & ~wd_block_q;
            s_we_o[hit_idx]  = bus_we;
        end
    end

    assign s_adr_o = hit_c ? (bus_adr & win_mask) : '0;
    assign s_dat_o = bus_dat;
    assign s_sel_o = bus_sel;

    // Terminations from the hit slave; ignored once the watchdog has fired
    assign slv_ack_c  = hit_c & ~wd_block_q & s_ack_i[hit_idx];
    assign slv_err_c  = hit_c & ~wd_block_q & s_err_i[hit_idx];
    assign slv_rty_c  = hit_c & ~wd_block_q & s_rty_i[hit_idx];
    assign slv_term_c = slv_ack_c | slv_err_c | slv_rty_c;

    // Default slave: one registered err per strobe to an unmapped address
    assign miss_c    = bus_cyc & bus_stb & ~hit_c;
    assign de_err_d  = miss_c & ~de_err_q & ~de_done_q;
    assign de_done_d = (de_done_q | de_err_q) & bus_stb;
    assign de_err_c  = de_err_q & miss_c;

    // Watchdog: counts unterminated strobe cycles to a mapped slave
    assign wd_active_c = hit_c & bus_stb & ~wd_block_q;
    assign wd_exp_c    = (TO_LIMIT != 16'd0) & wd_active_c & ~slv_term_c & (wd_cnt_q == TO_LIMIT);

    // Watchdog next-state
    always_comb begin
        wd_cnt_d   = wd_cnt_q + 16'd1;
        wd_block_d = (wd_block_q | wd_exp_c) & bus_cyc & bus_stb;
        tadr_d     = tadr_q;
        if (!wd_active_c || slv_term_c || wd_exp_c || (TO_LIMIT == 16'd0)) begin
            wd_cnt_d = '0;
        end
        if (wd_exp_c) begin
            tadr_d = bus_adr;
        end
    end

    // Watchdog and default-slave registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q   <= '0;
            wd_block_q <= 1'b0;
            tadr_q     <= '0;
            de_err_q   <= 1'b0;
            de_done_q  <= 1'b0;
        end else begin
            wd_cnt_q   <= wd_cnt_d;
            wd_block_q <= wd_block_d;
            tadr_q     <= tadr_d;
            de_err_q   <= de_err_d;
            de_done_q  <= de_done_d;
        end
    end

    assign m_dat_o       = hit_dat;
    assign m_ack_o       = gnt_q & {NUM_MASTERS{slv_ack_c}};
    assign m_rty_o       = gnt_q & {NUM_MASTERS{slv_rty_c}};
    assign m_err_o       = gnt_q & {NUM_MASTERS{slv_err_c | de_err_c | wd_exp_c}};
    assign gnt_o         = gnt_q;
    assign timeout_o     = wd_exp_c;
    assign timeout_adr_o = tadr_q;

endmodule

// File: tb/tb_wb_shared_intercon.sv
// Directed bench for wb_shared_intercon: arbitration, decode, default slave, watchdog, reset.
module tb_wb_shared_intercon;

    localparam int unsigned NM = 3;
    localparam int unsigned NS = 6;
    localparam int unsigned AW = 22;
    localparam int unsigned DW = 32;
    localparam logic [NS*AW-1:0] BASE = {22'h080000, 22'h040000, 22'h030000,
                                         22'h020000, 22'h010000, 22'h000000};
    localparam logic [NS*AW-1:0] MASK = {22'h03FFFF, 22'h33FFFF, 22'h00FFFF,
                                         22'h00FFFF, 22'h00FFFF, 22'h00FFFF};

    logic              clk;
    logic              rst_n;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*4-1:0]   m_sel;
    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack, m_err, m_rty;
    logic [NS-1:0]     s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_o;
    logic [3:0]        s_sel_o;
    logic [NS*DW-1:0]  s_dat;
    logic [NS-1:0]     s_ack, s_err, s_rty;
    logic [NM-1:0]     gnt;
    logic              tmo;
    logic [AW-1:0]     tmo_adr;

    int checks = 0;
    int errors = 0;

    wb_shared_intercon #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .AW(AW), .DW(DW),
        .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .gnt_o(gnt), .timeout_o(tmo), .timeout_adr_o(tmo_adr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [3:0] sel);
        m_cyc[i]           = cyc;
        m_stb[i]           = stb;
        m_we[i]            = we;
        m_adr[i*AW +: AW]  = adr;
        m_dat[i*DW +: DW]  = dat;
        m_sel[i*4 +: 4]    = sel;
    endtask

    task automatic idle_all();
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_adr = '0; m_dat = '0; m_sel = '0;
        s_ack = '0; s_err = '0; s_rty = '0;
    endtask

    task automatic release_bus();
        idle_all();
        nxt();
        nxt();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        for (int k = 0; k < int'(NS); k++) s_dat[k*DW +: DW] = 32'h1111_0000 + 32'(k);
        s_dat[4*DW +: DW] = 32'hDEAD_BEEF;
        #12;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        checks++; if (s_cyc !== 6'b0 || s_stb !== 6'b0) begin errors++; $display("FAIL reset_sctl: cyc %b stb %b want 0", s_cyc, s_stb); end
        checks++; if ((m_ack | m_err | m_rty) !== 3'b000) begin errors++; $display("FAIL reset_mterm: got %b want 000", m_ack | m_err | m_rty); end
        checks++; if (tmo !== 1'b0 || tmo_adr !== 22'h0) begin errors++; $display("FAIL reset_tmo: tmo %b adr %h want 0/0", tmo, tmo_adr); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        nxt();
    endtask

    task automatic test_arbitration();
        set_m(0, 1, 0, 0, 22'h000100, 0, 0);
        set_m(2, 1, 0, 0, 22'h010200, 0, 0);
        settle();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL arb_wait: got %b want 000", gnt); end
        nxt(); settle();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL arb_first: got %b want 001", gnt); end
        checks++; if (s_cyc !== 6'b000001) begin errors++; $display("FAIL arb_scyc0: got %b want 000001", s_cyc); end
        nxt(); m_cyc[0] = 1'b0; settle();
        checks++; if (gnt !== 3'b001 || s_cyc !== 6'b0) begin errors++; $display("FAIL arb_drop: gnt %b scyc %b want 001/0", gnt, s_cyc); end
        nxt(); settle();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL arb_gap: got %b want 000", gnt); end
        nxt(); m_cyc[0] = 1'b1; settle();
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL arb_second: got %b want 100", gnt); end
        checks++; if (s_cyc !== 6'b000010) begin errors++; $display("FAIL arb_scyc1: got %b want 000010", s_cyc); end
        nxt(); m_cyc[2] = 1'b0; settle();
        nxt(); settle();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL arb_gap2: got %b want 000", gnt); end
        nxt(); settle();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL arb_third: got %b want 001", gnt); end
        nxt(); m_cyc[0] = 1'b0; m_cyc[1] = 1'b1; settle();
        nxt(); m_cyc[0] = 1'b1; settle();
        nxt(); settle();
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL arb_rr_loses: got %b want 010", gnt); end
        release_bus();
    endtask

    task automatic test_read();
        set_m(1, 1, 1, 0, 22'h041234, 0, 4'hF);
        nxt(); settle();
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL rd_gnt: got %b want 010", gnt); end
        checks++; if (s_stb !== 6'b010000 || s_cyc !== 6'b010000) begin errors++; $display("FAIL rd_sel: stb %b cyc %b want 010000", s_stb, s_cyc); end
        checks++; if (s_adr !== 22'h001234) begin errors++; $display("FAIL rd_adr: got %h want 001234", s_adr); end
        checks++; if (m_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_dat: got %h want deadbeef", m_dat_o); end
        s_ack[4] = 1'b1;
        #1;
        checks++; if (m_ack !== 3'b010 || m_err !== 3'b000) begin errors++; $display("FAIL rd_ack: ack %b err %b want 010/000", m_ack, m_err); end
        release_bus();
    endtask

    task automatic test_write();
        set_m(1, 1, 1, 1, 22'h080044, 32'hCAFE_F00D, 4'h3);
        nxt(); settle();
        checks++; if (s_stb !== 6'b100000 || s_we !== 6'b100000) begin errors++; $display("FAIL wr_sel: stb %b we %b want 100000", s_stb, s_we); end
        checks++; if (s_adr !== 22'h000044) begin errors++; $display("FAIL wr_adr: got %h want 000044", s_adr); end
        checks++; if (s_dat_o !== 32'hCAFE_F00D || s_sel_o !== 4'h3) begin errors++; $display("FAIL wr_dat: dat %h sel %h want cafef00d/3", s_dat_o, s_sel_o); end
        s_rty[5] = 1'b1;
        #1;
        checks++; if (m_rty !== 3'b010 || m_ack !== 3'b000) begin errors++; $display("FAIL wr_rty: rty %b ack %b want 010/000", m_rty, m_ack); end
        release_bus();
    endtask

    task automatic test_unmapped();
        set_m(2, 1, 1, 0, 22'h3F0000, 0, 4'hF);
        nxt(); settle();
        checks++; if (gnt !== 3'b100 || s_cyc !== 6'b0) begin errors++; $display("FAIL um_nocyc: gnt %b scyc %b want 100/0", gnt, s_cyc); end
        checks++; if (m_err !== 3'b000 || m_dat_o !== 32'h0) begin errors++; $display("FAIL um_first: err %b dat %h want 000/0", m_err, m_dat_o); end
        nxt(); settle();
        checks++; if (m_err !== 3'b100) begin errors++; $display("FAIL um_err: got %b want 100", m_err); end
        nxt(); settle();
        checks++; if (m_err !== 3'b000) begin errors++; $display("FAIL um_once: got %b want 000", m_err); end
        release_bus();
    endtask

    task automatic test_timeout();
        set_m(0, 1, 1, 0, 22'h000010, 0, 4'hF);
        nxt(); settle();
        checks++; if (s_stb !== 6'b000001) begin errors++; $display("FAIL wd_start: got %b want 000001", s_stb); end
        for (int c = 2; c <= 8; c++) begin
            nxt(); settle();
            checks++; if (tmo !== 1'b0 || m_err !== 3'b000) begin errors++; $display("FAIL wd_early: cycle %0d tmo %b err %b want 0/000", c, tmo, m_err); end
        end
        nxt(); settle();
        checks++; if (tmo !== 1'b1) begin errors++; $display("FAIL wd_pulse: got %b want 1", tmo); end
        checks++; if (m_err !== 3'b001) begin errors++; $display("FAIL wd_err: got %b want 001", m_err); end
        nxt(); settle();
        checks++; if (s_stb !== 6'b0 || tmo !== 1'b0) begin errors++; $display("FAIL wd_block: stb %b tmo %b want 0/0", s_stb, tmo); end
        checks++; if (tmo_adr !== 22'h000010) begin errors++; $display("FAIL wd_adr: got %h want 000010", tmo_adr); end
        s_ack[0] = 1'b1;
        #1;
        checks++; if (m_ack !== 3'b000 || m_err !== 3'b000) begin errors++; $display("FAIL wd_late_ack: ack %b err %b want 000/000", m_ack, m_err); end
        release_bus();
    endtask

    task automatic test_ack_on_expiry();
        set_m(0, 1, 1, 0, 22'h000020, 0, 4'hF);
        nxt();
        for (int c = 2; c <= 9; c++) nxt();
        s_ack[0] = 1'b1;
        settle();
        checks++; if (m_ack !== 3'b001) begin errors++; $display("FAIL exp_ack: got %b want 001", m_ack); end
        checks++; if (m_err !== 3'b000 || tmo !== 1'b0) begin errors++; $display("FAIL exp_noerr: err %b tmo %b want 000/0", m_err, tmo); end
        checks++; if (tmo_adr !== 22'h000010) begin errors++; $display("FAIL exp_adr_kept: got %h want 000010", tmo_adr); end
        release_bus();
    endtask

    task automatic test_reset_mid();
        set_m(1, 1, 1, 0, 22'h041234, 0, 4'hF);
        nxt(); nxt(); settle();
        checks++; if (s_stb !== 6'b010000) begin errors++; $display("FAIL rm_pre: got %b want 010000", s_stb); end
        s_ack[4] = 1'b1;
        #1;
        checks++; if (m_ack !== 3'b010) begin errors++; $display("FAIL rm_pre_ack: got %b want 010", m_ack); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rm_gnt: got %b want 000", gnt); end
        checks++; if (s_cyc !== 6'b0 || s_stb !== 6'b0 || s_we !== 6'b0) begin errors++; $display("FAIL rm_sctl: cyc %b stb %b we %b want 0", s_cyc, s_stb, s_we); end
        checks++; if ((m_ack | m_err | m_rty) !== 3'b000 || tmo !== 1'b0) begin errors++; $display("FAIL rm_mterm: term %b tmo %b want 000/0", m_ack | m_err | m_rty, tmo); end
        idle_all();
        set_m(0, 1, 0, 0, 22'h000100, 0, 0);
        set_m(1, 1, 0, 0, 22'h010100, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        nxt(); settle();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rm_restart: got %b want 001", gnt); end
        release_bus();
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_ack_on_expiry();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
